// File: rtl/axi4_lite_write_master_pkg.sv
// Shared AXI4-Lite definitions: response codes and the 2-bit channel FSM encoding.
// No ports; imported by the write master and by the future read master.
// The state encoding is fixed so both masters present the same values on debug taps.
package axi4_lite_write_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEND   = 2'b01,
    ST_WAIT_B = 2'b10,
    ST_DONE   = 2'b11
  } axil_state_e;

endpackage

// File: rtl/axi4_lite_write_master.sv
// AXI4-Lite write master: takes one LSU store, issues AW and W with independent
// handshakes, waits for B and returns a one-cycle DONE pulse with the response.
// Ports: CLK/RST_N (sync active-low); REQ_* from LSU; DONE_* to LSU; AW_*, W_*, B_* to slave.
// Min latency accept->DONE is 3 cycles; REQ_READY only in IDLE, so one transaction in flight.
module axi4_lite_write_master
  import axi4_lite_write_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned STRB_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_DATA,
  input  logic [STRB_W-1:0] REQ_STRB,
  output logic              DONE_VALID,
  output logic [1:0]        DONE_RESP,
  output logic [ADDR_W-1:0] AW_ADDR,
  output logic              AW_VALID,
  input  logic              AW_READY,
  output logic [DATA_W-1:0] W_DATA,
  output logic [STRB_W-1:0] W_STRB,
  output logic              W_VALID,
  input  logic              W_READY,
  input  logic [1:0]        B_RESP,
  input  logic              B_VALID,
  output logic              B_READY
);

  localparam bit          WDOG_EN   = (TIMEOUT_CYC > 0);
  localparam logic [31:0] WDOG_LAST = WDOG_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  axil_state_e       state_q, state_d;
  logic              aw_pend_q, aw_pend_d;
  logic              w_pend_q, w_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              b_ready_q, b_ready_d;
  logic [1:0]        resp_q, resp_d;
  logic [31:0]       wdog_q, wdog_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      b_ready_q <= 1'b0;
      resp_q    <= RESP_OKAY;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      b_ready_q <= b_ready_d;
      resp_q    <= resp_d;
      wdog_q    <= wdog_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    b_ready_d = b_ready_q;
    resp_d    = resp_q;
    wdog_d    = wdog_q;

    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          addr_d    = REQ_ADDR;
          data_d    = REQ_DATA;
          strb_d    = REQ_STRB;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        // Each channel retires on its own handshake; leave once neither is pending,
        // which also covers both handshakes landing in the same cycle.
        if (aw_pend_q && AW_READY) aw_pend_d = 1'b0;
        if (w_pend_q && W_READY)   w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) begin
          state_d   = ST_WAIT_B;
          b_ready_d = 1'b1;
          wdog_d    = '0;
        end
      end
      ST_WAIT_B: begin
        // A real B wins over a watchdog expiry in the same cycle.
        if (B_VALID) begin
          resp_d    = B_RESP;
          b_ready_d = 1'b0;
          state_d   = ST_DONE;
        end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
          resp_d    = RESP_SLVERR;
          b_ready_d = 1'b0;
          state_d   = ST_DONE;
        end else if (WDOG_EN) begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign REQ_READY  = (state_q == ST_IDLE);
  assign AW_VALID   = aw_pend_q;
  assign W_VALID    = w_pend_q;
  // Payload is only presented in SEND so the bus reads as zero when idle.
  assign AW_ADDR    = (state_q == ST_SEND) ? addr_q : '0;
  assign W_DATA     = (state_q == ST_SEND) ? data_q : '0;
  assign W_STRB     = (state_q == ST_SEND) ? strb_q : '0;
  assign B_READY    = b_ready_q;
  assign DONE_VALID = (state_q == ST_DONE);
  assign DONE_RESP  = (state_q == ST_DONE) ? resp_q : RESP_OKAY;

endmodule

// File: tb/tb_axi4_lite_write_master.sv
module tb_axi4_lite_write_master;

  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [63:0] REQ_ADDR = '0;
  logic [63:0] REQ_DATA = '0;
  logic [7:0]  REQ_STRB = '0;
  logic        DONE_VALID;
  logic [1:0]  DONE_RESP;
  logic [63:0] AW_ADDR;
  logic        AW_VALID;
  logic        AW_READY = 1'b0;
  logic [63:0] W_DATA;
  logic [7:0]  W_STRB;
  logic        W_VALID;
  logic        W_READY = 1'b0;
  logic [1:0]  B_RESP = 2'b00;
  logic        B_VALID = 1'b0;
  logic        B_READY;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  axi4_lite_write_master #(
    .ADDR_W(64), .DATA_W(64), .STRB_W(8), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_STRB(REQ_STRB),
    .DONE_VALID(DONE_VALID), .DONE_RESP(DONE_RESP),
    .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One store, timeline derived from the protocol rules: channel X's READY rises
  // x_dly cycles into SEND and stays up; B arrives b_dly cycles into WAIT_B.
  // If B would come later than TO cycles into WAIT_B, the watchdog completes with SLVERR.
  task automatic do_txn(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                        input int aw_dly, input int w_dly, input int b_dly,
                        input logic [1:0] br, input bit hold);
    int last;
    int n_wait;
    bit timed_out;
    logic [1:0] exp_resp;
    REQ_ADDR  = a;
    REQ_DATA  = d;
    REQ_STRB  = s;
    REQ_VALID = 1'b1;
    chk("idle_req_ready", REQ_READY, 1'b1);
    chk("idle_done", DONE_VALID, 1'b0);
    accept_cyc = cyc;
    tick();
    if (hold) begin
      // A different request left pending at the LSU must not disturb this one.
      REQ_ADDR = ~a;
      REQ_DATA = ~d;
      REQ_STRB = ~s;
    end else begin
      REQ_VALID = 1'b0;
    end
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int k = 0; k <= last; k++) begin
      AW_READY = (k >= aw_dly);
      W_READY  = (k >= w_dly);
      chk("send_aw_valid", AW_VALID, (k <= aw_dly));
      chk("send_w_valid", W_VALID, (k <= w_dly));
      if (k <= aw_dly) chk("send_aw_addr", AW_ADDR, a);
      if (k <= w_dly) begin
        chk("send_w_data", W_DATA, d);
        chk("send_w_strb", {56'd0, W_STRB}, {56'd0, s});
      end
      chk("send_req_ready", REQ_READY, 1'b0);
      chk("send_b_ready", B_READY, 1'b0);
      tick();
    end
    AW_READY = 1'b0;
    W_READY  = 1'b0;
    timed_out = (b_dly > TO - 1);
    n_wait    = timed_out ? TO : b_dly + 1;
    exp_resp  = timed_out ? 2'b10 : br;
    for (int j = 0; j < n_wait; j++) begin
      B_VALID = (j >= b_dly);
      B_RESP  = br;
      chk("waitb_b_ready", B_READY, 1'b1);
      chk("waitb_aw_valid", AW_VALID, 1'b0);
      chk("waitb_w_valid", W_VALID, 1'b0);
      chk("waitb_done", DONE_VALID, 1'b0);
      tick();
    end
    // A late B after the watchdog fired must see B_READY low.
    B_VALID = timed_out;
    chk("done_valid", DONE_VALID, 1'b1);
    chk("done_resp", {62'd0, DONE_RESP}, {62'd0, exp_resp});
    chk("done_b_ready", B_READY, 1'b0);
    chk("done_req_ready", REQ_READY, 1'b0);
    tick();
    B_VALID = 1'b0;
    chk("post_done_valid", DONE_VALID, 1'b0);
    chk("post_req_ready", REQ_READY, 1'b1);
    chk("post_b_ready", B_READY, 1'b0);
    chk("post_aw_valid", AW_VALID, 1'b0);
    REQ_VALID = 1'b0;
  endtask

  initial begin
    int prev;
    RST_N = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", REQ_READY, 1'b1);
    chk("rst_aw_valid", AW_VALID, 1'b0);
    chk("rst_w_valid", W_VALID, 1'b0);
    chk("rst_b_ready", B_READY, 1'b0);
    chk("rst_done_valid", DONE_VALID, 1'b0);
    chk("rst_done_resp", {62'd0, DONE_RESP}, 64'd0);
    chk("rst_aw_addr", AW_ADDR, 64'd0);
    RST_N = 1'b1;
    tick();

    // Minimum latency, both channels ready, OKAY.
    do_txn(64'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 0, 0, 0, 2'b00, 1'b0);
    // W first, AW three cycles later.
    do_txn(64'h1234_5678_9ABC_DEF0, 64'h0123_4567_89AB_CDEF, 8'hF0, 3, 0, 0, 2'b00, 1'b0);
    // AW first, W later.
    do_txn(64'h40, 64'h55AA_55AA_55AA_55AA, 8'h3C, 0, 2, 1, 2'b01, 1'b0);
    // Slow B with DECERR.
    do_txn(64'h80, 64'hCAFE_F00D, 8'hFF, 0, 0, 5, 2'b11, 1'b0);
    // B just inside the watchdog window.
    do_txn(64'h88, 64'h1, 8'h01, 1, 1, TO - 1, 2'b00, 1'b0);
    // No B at all: watchdog completes with SLVERR.
    do_txn(64'h90, 64'h2, 8'h02, 0, 0, 100, 2'b00, 1'b0);

    // Reset while in SEND abandons the transaction silently.
    REQ_ADDR  = 64'hABCD;
    REQ_DATA  = 64'h77;
    REQ_STRB  = 8'h11;
    REQ_VALID = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    chk("pre_rst_aw_valid", AW_VALID, 1'b1);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("midrst_aw_valid", AW_VALID, 1'b0);
    chk("midrst_w_valid", W_VALID, 1'b0);
    chk("midrst_req_ready", REQ_READY, 1'b1);
    chk("midrst_done", DONE_VALID, 1'b0);
    chk("midrst_b_ready", B_READY, 1'b0);
    tick();
    chk("midrst_done_after", DONE_VALID, 1'b0);

    // Back-to-back with REQ_VALID held: accepts land exactly 4 cycles apart.
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      do_txn(64'h1000 + 64'(i * 8), 64'hA0 + 64'(i), 8'h0F << i, 0, 0, 0, 2'b00, 1'b1);
      if (prev >= 0) chk("b2b_spacing", 64'(accept_cyc - prev), 64'd4);
      prev = accept_cyc;
    end

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      do_txn({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 10)), 2'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
